input_debouncer: RTL and testbench

//  Conditions a raw, asynchronous, bouncy input (switch, button, off-chip strobe)

---
 rtl/input_debouncer.sv | 124 ++++++++++++
 tb/tb_input_debouncer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronises and debounces a raw asynchronous input into a clean level,
// with one-cycle rise/fall pulses and a busy flag while a change is qualified.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_LEVEL     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    // state     | meaning
    // STABLE_LO | d_out=0, waiting for s=1
    // CHK_HI    | s=1 seen, counting consecutive high samples
    // STABLE_HI | d_out=1, waiting for s=0
    // CHK_LO    | s=0 seen, counting consecutive low samples
    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic            RST_LVL  = (RESET_LEVEL != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   d_out_q, d_out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    d_out_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    d_out_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_LVL ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
            d_out_q <= RST_LVL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // busy comes from registered state only, so no combinational path from din_raw
    assign busy  = (state_q == CHK_HI) || (state_q == CHK_LO);
    assign d_out = d_out_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: a run-length reference model predicts
// {d_out,rise,fall,busy} for every edge; each scenario task compares inline.
module tb_input_debouncer;

    localparam int DEB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din_raw = 1'b0;
    logic d_out, rise, fall, busy;

    logic reset2 = 1'b1;
    logic din2 = 1'b1;
    logic d_out2, rise2, fall2, busy2;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];

    logic [1:0] m_sync;
    logic       m_dout, m_rise, m_fall, m_busy;
    int         m_run;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(0)) dut (
        .clk(clk), .reset(reset), .din_raw(din_raw),
        .d_out(d_out), .rise(rise), .fall(fall), .busy(busy)
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(1)) dut_hi (
        .clk(clk), .reset(reset2), .din_raw(din2),
        .d_out(d_out2), .rise(rise2), .fall(fall2), .busy(busy2)
    );

    function automatic void m_reset();
        m_sync = 2'b00;
        m_dout = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
        m_run  = 0;
    endfunction

    // Level flips once the synchronised input has disagreed with it on DEB consecutive edges.
    function automatic void m_edge(input logic din);
        logic s;
        s = m_sync[1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_dout) begin
            m_run++;
            if (m_run == DEB) begin
                m_dout = s;
                m_rise = s;
                m_fall = ~s;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        m_busy = (m_run != 0);
        m_sync = {m_sync[0], din};
    endfunction

    task automatic step(input logic din, output logic [3:0] got, output logic [3:0] exp);
        @(negedge clk);
        din_raw = din;
        m_edge(din);
        exp_q.push_back({m_dout, m_rise, m_fall, m_busy});
        @(posedge clk);
        #1;
        got = {d_out, rise, fall, busy};
        exp = exp_q.pop_front();
    endtask

    task automatic async_reset_mid_cycle(output logic [3:0] got);
        #2;
        reset = 1'b1;
        #1;
        got = {d_out, rise, fall, busy};
        m_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got, exp;
        #2;
        vectors++;
        if ({d_out, rise, fall, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_init got=%b exp=0000", {d_out, rise, fall, busy});
        end
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_prep i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        vectors++;
        if (d_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prep_level got=%b exp=1", d_out);
        end
        async_reset_mid_cycle(got);
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async got=%b exp=0000", got);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, got, exp);
            vectors++;
            if (got !== exp || got !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_after i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_rise_latency();
        logic [3:0] got, exp;
        int busy_edge, rise_edge;
        busy_edge = 0;
        rise_edge = 0;
        for (int e = 1; e <= 19; e++) begin
            step(1'b1, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rise_seq edge=%0d got=%b exp=%b", e, got, exp);
            end
            if (got[0] === 1'b1 && busy_edge == 0) busy_edge = e;
            if (got[2] === 1'b1 && rise_edge == 0) rise_edge = e;
            if (e == 19) begin
                vectors++;
                if (got[2] !== 1'b0 || got[3] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rise_edge19 got=%b exp=1000", got);
                end
            end
        end
        vectors++;
        if (busy_edge != 3) begin
            miscompares++;
            $display("FAIL busy_edge got=%0d exp=3", busy_edge);
        end
        vectors++;
        if (rise_edge != 18) begin
            miscompares++;
            $display("FAIL rise_edge got=%0d exp=18", rise_edge);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rise_return i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] got, exp;
        int rises, busy_seen;
        rises = 0;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(i < 10 ? 1'b1 : 1'b0, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch_seq i=%0d got=%b exp=%b", i, got, exp);
            end
            if (got[2] === 1'b1) rises++;
            if (got[0] === 1'b1) busy_seen++;
        end
        vectors++;
        if (rises != 0 || busy_seen == 0 || d_out !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_summary rises=%0d busy_cycles=%0d d_out=%b busy=%b exp rises=0 busy_cycles>0 d_out=0 busy=0",
                     rises, busy_seen, d_out, busy);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] got, exp;
        int falls, rises, fall_idx;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL bounce_prep i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        falls = 0;
        rises = 0;
        fall_idx = -1;
        // steps 0..39 bounce in groups of three starting low; held low from step 40
        for (int i = 0; i < 70; i++) begin
            step((i < 40 && ((i / 3) % 2) == 1) ? 1'b1 : 1'b0, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL bounce_seq i=%0d got=%b exp=%b", i, got, exp);
            end
            if (got[1] === 1'b1) begin
                falls++;
                fall_idx = i;
            end
            if (got[2] === 1'b1) rises++;
        end
        vectors++;
        if (falls != 1 || rises != 0 || fall_idx != 57) begin
            miscompares++;
            $display("FAIL bounce_summary falls=%0d rises=%0d fall_step=%0d exp falls=1 rises=0 fall_step=57",
                     falls, rises, fall_idx);
        end
    endtask

    task automatic test_reset_mid_qual();
        logic [3:0] got, exp;
        int rise_edge;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midq_seq i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midq_busy got=%b exp=1", busy);
        end
        async_reset_mid_cycle(got);
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL midq_reset got=%b exp=0000", got);
        end
        rise_edge = 0;
        for (int e = 1; e <= 40 && rise_edge == 0; e++) begin
            step(1'b1, got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midq_requal edge=%0d got=%b exp=%b", e, got, exp);
            end
            if (got[2] === 1'b1) rise_edge = e;
        end
        vectors++;
        if (rise_edge != 18) begin
            miscompares++;
            $display("FAIL midq_rise_edge got=%0d exp=18", rise_edge);
        end
    endtask

    task automatic test_reset_level();
        vectors++;
        if ({d_out2, rise2, fall2, busy2} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rstlvl_reset got=%b exp=1000", {d_out2, rise2, fall2, busy2});
        end
        @(negedge clk);
        reset2 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({d_out2, rise2, fall2, busy2} !== 4'b1000) begin
                miscompares++;
                $display("FAIL rstlvl_run i=%0d got=%b exp=1000", i, {d_out2, rise2, fall2, busy2});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_bounce();
        test_reset_mid_qual();
        test_reset_level();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
